opt_stream_cipher: RTL and testbench



---
 rtl/opt_stream_cipher_if.sv | 24 ++
 rtl/opt_stream_cipher.sv | 164 ++++++++++++++++
 tb/tb_opt_stream_cipher.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/opt_stream_cipher_if.sv
// Streaming interface for opt_stream_cipher.
//   in_valid/in_ready/in_data    : word stream into the cipher
//   out_valid/out_ready/out_data : result stream out of the cipher
// master = producer/consumer side (testbench, pin wrapper), slave = cipher.
interface opt_stream_cipher_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/opt_stream_cipher.sv
// opt_stream_cipher: reversible keystream cipher over DATA_W-bit words.
// A multi-word key (MSB word first) seeds a Galois LFSR; the low DATA_W
// bits of the LFSR are the keystream, stepped once per accepted word.
// One registered output stage with valid/ready on both sides.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : global enable, low freezes all state
//   key_load   : strobe, shift key_in into the key register
//   key_in     : key word
//   mode       : 0 encrypt, 1 decrypt (latched on key completion/restart)
//   restart    : strobe, reseed LFSR, relatch mode, flush output (RUN only)
//   bus        : stream interface (slave modport)
//   keyed      : key complete, block in RUN
//
// Build option: define OPT_CHAIN_EN to enable ciphertext chaining
// (each word is additionally XORed with the previous ciphertext word).
//
// state    | meaning
// ---------+------------------------------------------------
// UNKEYED  | after reset, no key words received
// LOAD     | collecting key words, count in cnt_q
// RUN      | key complete, stream words are accepted
module opt_stream_cipher #(
  parameter int DATA_W    = 8,
  parameter int KEY_WORDS = 2,
  parameter logic [DATA_W*KEY_WORDS-1:0] TAPS = 16'hB400,
  parameter int ROT       = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                key_load,
  input  logic [DATA_W-1:0]   key_in,
  input  logic                mode,
  input  logic                restart,
  opt_stream_cipher_if.slave  bus,
  output logic                keyed
);

  localparam int L     = DATA_W * KEY_WORDS;
  localparam int CNT_W = $clog2(KEY_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(KEY_WORDS - 1);

  typedef enum logic [1:0] {S_UNKEYED, S_LOAD, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [L-1:0]      key_q, key_shifted;
  logic [L-1:0]      lfsr_q, lfsr_step;
  logic [CNT_W-1:0]  cnt_q;
  logic              mode_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [DATA_W-1:0] ks, chain, result;
  logic              load_evt, key_done, restart_evt, accept, in_ready;

  // A zero seed would lock the LFSR at zero forever.
  function automatic logic [L-1:0] seed_of(input logic [L-1:0] k);
    return (k == '0) ? L'(1) : k;
  endfunction

  // Rotations via a doubled word so ROT == 0 needs no special case.
  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] x);
    logic [2*DATA_W-1:0] d;
    d = {x, x} << ROT;
    return d[2*DATA_W-1:DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x);
    logic [2*DATA_W-1:0] d;
    d = {x, x} >> ROT;
    return d[DATA_W-1:0];
  endfunction

  assign key_shifted = (key_q << DATA_W) | L'(key_in);
  assign load_evt    = ena && key_load;
  // From UNKEYED or RUN a key_load is the first word of a new key.
  assign key_done    = load_evt &&
                       ((state_q == S_LOAD) ? (cnt_q == LAST_CNT) : (KEY_WORDS == 1));
  assign restart_evt = ena && !key_load && restart && (state_q == S_RUN);

  assign in_ready = ena && (state_q == S_RUN) && !key_load && !restart &&
                    (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  assign ks        = lfsr_q[DATA_W-1:0];
  assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
  assign result    = mode_q ? (rotr(bus.in_data) ^ ks ^ chain)
                            : rotl(bus.in_data ^ ks ^ chain);

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign keyed         = (state_q == S_RUN);

  always_comb begin
    state_d = state_q;
    if (load_evt) begin
      state_d = key_done ? S_RUN : S_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_UNKEYED;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q       <= '0;
      cnt_q       <= '0;
      lfsr_q      <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (ena) begin
      if (key_load) begin
        key_q       <= key_shifted;
        out_valid_q <= 1'b0;
        if (key_done) begin
          cnt_q  <= '0;
          lfsr_q <= seed_of(key_shifted);
          mode_q <= mode;
        end else begin
          cnt_q <= (state_q == S_LOAD) ? cnt_q + CNT_W'(1) : CNT_W'(1);
        end
      end else if (restart_evt) begin
        lfsr_q      <= seed_of(key_q);
        mode_q      <= mode;
        out_valid_q <= 1'b0;
      end else if (accept) begin
        out_data_q  <= result;
        out_valid_q <= 1'b1;
        lfsr_q      <= lfsr_step;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef OPT_CHAIN_EN
  // Chain holds the last ciphertext word: the output when encrypting,
  // the input when decrypting, so both directions stay in lockstep.
  logic [DATA_W-1:0] chain_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else if (key_done || restart_evt) begin
      chain_q <= '0;
    end else if (accept) begin
      chain_q <= mode_q ? bus.in_data : result;
    end
  end

  assign chain = chain_q;
`else
  assign chain = '0;
`endif

endmodule

// File: tb/tb_opt_stream_cipher.sv
module tb_opt_stream_cipher;
  localparam int DATA_W = 8;
  localparam int KW     = 2;
  localparam logic [15:0] TAPS = 16'hB400;
  localparam int ROT    = 1;
`ifdef OPT_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       key_load = 1'b0;
  logic [7:0] key_in = '0;
  logic       mode = 1'b0;
  logic       restart = 1'b0;
  logic       keyed;

  opt_stream_cipher_if #(.DATA_W(DATA_W)) bus ();

  opt_stream_cipher #(
    .DATA_W(DATA_W), .KEY_WORDS(KW), .TAPS(TAPS), .ROT(ROT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .key_load(key_load),
    .key_in(key_in), .mode(mode), .restart(restart), .bus(bus.slave),
    .keyed(keyed)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Reference model: what the block should hold after each clock edge.
  bit        m_keyed, m_mode, m_ov;
  int        m_cnt;
  logic [15:0] m_key, m_lfsr;
  logic [7:0]  m_chain, m_od;

  function automatic logic [7:0] ref_rotl(input logic [7:0] x);
    int v;
    v = ((int'(x) << ROT) | (int'(x) >> (8 - ROT))) & 255;
    return v[7:0];
  endfunction

  function automatic logic [7:0] ref_rotr(input logic [7:0] x);
    int v;
    v = ((int'(x) >> ROT) | (int'(x) << (8 - ROT))) & 255;
    return v[7:0];
  endfunction

  task automatic model_reset();
    m_keyed = 0; m_mode = 0; m_ov = 0; m_cnt = 0;
    m_key = '0; m_lfsr = '0; m_chain = '0; m_od = '0;
  endtask

  task automatic model_update(input bit exp_ready);
    logic [7:0] ks, w;
    if (!ena) return;
    if (key_load) begin
      m_ov  = 0;
      m_key = {m_key[7:0], key_in};
      if (m_keyed) m_cnt = 1; else m_cnt = m_cnt + 1;
      m_keyed = 0;
      if (m_cnt == KW) begin
        m_keyed = 1; m_cnt = 0;
        m_lfsr  = (m_key == 0) ? 16'h0001 : m_key;
        m_chain = '0; m_mode = mode;
      end
    end else if (restart && m_keyed) begin
      m_lfsr  = (m_key == 0) ? 16'h0001 : m_key;
      m_chain = '0; m_mode = mode; m_ov = 0;
    end else if (bus.in_valid && exp_ready) begin
      w  = bus.in_data;
      ks = m_lfsr[7:0];
      if (!m_mode) m_od = ref_rotl(w ^ ks ^ m_chain);
      else         m_od = ref_rotr(w) ^ ks ^ m_chain;
      if (CHAIN) m_chain = m_mode ? w : m_od;
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ TAPS) : (m_lfsr >> 1);
      m_ov = 1;
    end else if (m_ov && bus.out_ready) begin
      m_ov = 0;
    end
  endtask

  // Called at a falling edge with inputs set; advances one clock.
  task automatic step();
    bit exp_ready;
    #1;
    exp_ready = ena && m_keyed && !key_load && !restart && (!m_ov || bus.out_ready);
    check_eq("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready});
    model_update(exp_ready);
    @(posedge clk);
    @(negedge clk);
    check_eq("out_valid", {31'd0, bus.out_valid}, {31'd0, m_ov});
    check_eq("out_data", {24'd0, bus.out_data}, {24'd0, m_od});
    check_eq("keyed", {31'd0, keyed}, {31'd0, m_keyed});
  endtask

  task automatic idle_inputs();
    ena = 1; key_load = 0; restart = 0;
    bus.in_valid = 0; bus.out_ready = 1;
  endtask

  task automatic load_key(input logic [7:0] k1, input logic [7:0] k0, input bit md);
    idle_inputs();
    mode = md;
    key_load = 1; key_in = k1; step();
    key_in = k0; step();
    key_load = 0;
  endtask

  task automatic send(input logic [7:0] w);
    bus.in_valid = 1; bus.in_data = w; step();
    bus.in_valid = 0;
  endtask

  logic [7:0] hold;

  initial begin
    model_reset();
    idle_inputs();
    bus.in_valid = 1; bus.in_data = 8'hAA;
    rst_n = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("rst_out_data", {24'd0, bus.out_data}, 32'd0);
    check_eq("rst_keyed", {31'd0, keyed}, 32'd0);
    check_eq("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    rst_n = 1;
    repeat (3) step();
    check_eq("idle_no_output", {31'd0, bus.out_valid}, 32'd0);

    // Zero key: seed 1, encrypt 0xFF twice
    load_key(8'h00, 8'h00, 1'b0);
    check_eq("keyed_after_load", {31'd0, keyed}, 32'd1);
    send(8'hFF);
    check_eq("enc_w0", {24'd0, bus.out_data}, 32'h0FD);
    send(8'hFF);
    check_eq("enc_w1", {24'd0, bus.out_data}, CHAIN ? 32'h004 : 32'h0FF);
    step();

    // Decrypt round trip
    mode = 1; restart = 1; step(); restart = 0;
    send(8'hFD);
    check_eq("dec_w0", {24'd0, bus.out_data}, 32'h0FF);
    send(CHAIN ? 8'h04 : 8'hFF);
    check_eq("dec_w1", {24'd0, bus.out_data}, 32'h0FF);
    step();

    // Mode change without restart has no effect
    mode = 0; restart = 1; step(); restart = 0;
    mode = 1;
    send(8'hFF);
    check_eq("mode_no_restart", {24'd0, bus.out_data}, 32'h0FD);
    step();

    // Back-pressure
    bus.out_ready = 0;
    send(8'h5A);
    hold = bus.out_data;
    bus.in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = 8'($urandom);
      step();
      check_eq("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check_eq("bp_data_stable", {24'd0, bus.out_data}, {24'd0, hold});
    end
    bus.out_ready = 1;
    #1 check_eq("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    check_eq("bp_release_valid", {31'd0, bus.out_valid}, 32'd1);

    // key_load with in_valid in RUN: no accept, key reload starts
    key_load = 1; key_in = 8'h33; bus.in_valid = 1;
    #1 check_eq("kl_in_ready", {31'd0, bus.in_ready}, 32'd0);
    step();
    check_eq("kl_keyed_drop", {31'd0, keyed}, 32'd0);
    check_eq("kl_out_valid", {31'd0, bus.out_valid}, 32'd0);
    key_in = 8'hC5; bus.in_valid = 0; step();
    key_load = 0;
    send(8'h12);
    send(8'h34);

    // ena low freezes everything
    bus.out_ready = 0; send(8'h77);
    ena = 0; bus.in_valid = 1; bus.out_ready = 1; key_load = 1; restart = 1;
    repeat (3) step();
    idle_inputs(); step();

    // Reset in the middle of a key load
    key_load = 1; key_in = 8'h9C; step(); key_load = 0;
    #2 rst_n = 0;
    #1 check_eq("midload_rst_keyed", {31'd0, keyed}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    step();

    // Randomised traffic
    load_key(8'($urandom), 8'($urandom), 1'($urandom));
    for (int i = 0; i < 1500; i++) begin
      ena           = ($urandom_range(0, 99) < 93);
      key_load      = ($urandom_range(0, 99) < 3);
      key_in        = 8'($urandom);
      mode          = 1'($urandom);
      restart       = ($urandom_range(0, 99) < 4);
      bus.in_valid  = ($urandom_range(0, 99) < 70);
      bus.in_data   = 8'($urandom);
      bus.out_ready = ($urandom_range(0, 99) < 70);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
